joypad_reader: RTL and testbench

JOYPAD_READER -- requirements
Module: joypad_reader

---
 rtl/joypad_reader.sv | 146 ++++++++++++++
 tb/tb_joypad_reader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_reader.sv
// Serial reader for two shift-register game pads sharing one latch/clock pair.
// A scan strobes pad_latch, then shifts eight buttons out of both pads in
// lockstep and publishes them together on joycon_1/joycon_2 with a valid pulse.
module joypad_reader #(
  parameter int DIV = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       pad1_data,
  input  logic       pad2_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] joycon_1,
  output logic [7:0] joycon_2,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  // Last count of a half-phase; the counter runs 0..DIV-1 inside each phase.
  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  state_t     state, state_nx;
  logic [7:0] phase_cnt, phase_cnt_nx;
  logic [2:0] bit_idx, bit_idx_nx;
  logic [7:0] cap_1, cap_1_nx;
  logic [7:0] cap_2, cap_2_nx;
  logic       joy_load;
  logic       phase_last;

  assign phase_last = (phase_cnt == DIV_M1);

  // Next-state, phase timing and bit capture; pads are active-low so data is inverted on capture.
  always_comb begin
    state_nx     = state;
    phase_cnt_nx = phase_last ? 8'd0 : phase_cnt + 8'd1;
    bit_idx_nx   = bit_idx;
    cap_1_nx     = cap_1;
    cap_2_nx     = cap_2;
    joy_load     = 1'b0;
    case (state)
      S_IDLE: begin
        phase_cnt_nx = 8'd0;
        bit_idx_nx   = 3'd0;
        if (poll_req) begin
          state_nx = S_LATCH;
        end
      end
      S_LATCH: begin
        // The latch lasts two half-phases; bit_idx[0] marks the second one so
        // the 8-bit counter never has to reach 2*DIV.
        if (phase_last) begin
          if (!bit_idx[0]) begin
            bit_idx_nx = 3'd1;
          end else begin
            bit_idx_nx = 3'd0;
            state_nx   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (phase_last) begin
          cap_1_nx[0] = ~pad1_data;
          cap_2_nx[0] = ~pad2_data;
          bit_idx_nx  = 3'd1;
          state_nx    = S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (phase_last) begin
          state_nx = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        if (phase_last) begin
          cap_1_nx[bit_idx] = ~pad1_data;
          cap_2_nx[bit_idx] = ~pad2_data;
          if (bit_idx == 3'd7) begin
            state_nx = S_DONE;
            joy_load = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            state_nx   = S_CLK_HI;
          end
        end
      end
      S_DONE: begin
        phase_cnt_nx = 8'd0;
        bit_idx_nx   = 3'd0;
        state_nx     = S_IDLE;
      end
      default: begin
        phase_cnt_nx = 8'd0;
        bit_idx_nx   = 3'd0;
        state_nx     = S_IDLE;
      end
    endcase
  end

  // State, counters and capture registers; reset discards any partial scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase_cnt <= 8'd0;
      bit_idx   <= 3'd0;
      cap_1     <= 8'h00;
      cap_2     <= 8'h00;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_cnt_nx;
      bit_idx   <= bit_idx_nx;
      cap_1     <= cap_1_nx;
      cap_2     <= cap_2_nx;
    end
  end

  // Published pad state: loaded on the edge entering DONE so it is visible
  // in the same cycle as the valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      joycon_1 <= 8'h00;
      joycon_2 <= 8'h00;
    end else if (joy_load) begin
      joycon_1 <= cap_1_nx;
      joycon_2 <= cap_2_nx;
    end
  end

  // Pad strobes and status are pure state decodes, so they cannot overlap.
  always_comb begin
    pad_latch = (state == S_LATCH);
    pad_clk   = (state == S_CLK_HI);
    busy      = (state != S_IDLE);
    valid     = (state == S_DONE);
  end

endmodule

// File: tb/tb_joypad_reader.sv
// Bench for joypad_reader: behavioural shift-register pad models, a scoreboard
// of expected button words checked on each valid pulse, and timing monitors.
module tb_joypad_reader;

  localparam int DIV  = 2;
  localparam int DIV1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic poll_req = 1'b1;
  logic poll1 = 1'b0;

  logic       pad_latch, pad_clk, busy, valid;
  logic [7:0] joycon_1, joycon_2;
  logic       pad1_data, pad2_data;

  logic       latch1, pclk1, busy1, valid1;
  logic [7:0] j1_1, j1_2;
  logic       pad1_b, pad2_b;

  logic [7:0] btn1 = 8'h5A;
  logic [7:0] btn2 = 8'h00;
  logic [7:0] sr1 = 8'h00, sr2 = 8'h00, sr1b = 8'h00, sr2b = 8'h00;

  logic [15:0] exp_q[$];
  logic [15:0] exp1_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  joypad_reader #(.DIV(DIV)) u_dut (
    .clk(clk), .rst(rst), .poll_req(poll_req),
    .pad1_data(pad1_data), .pad2_data(pad2_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk),
    .joycon_1(joycon_1), .joycon_2(joycon_2),
    .busy(busy), .valid(valid)
  );

  joypad_reader #(.DIV(DIV1)) u_dut1 (
    .clk(clk), .rst(rst), .poll_req(poll1),
    .pad1_data(pad1_b), .pad2_data(pad2_b),
    .pad_latch(latch1), .pad_clk(pclk1),
    .joycon_1(j1_1), .joycon_2(j1_2),
    .busy(busy1), .valid(valid1)
  );

  // Pad model: parallel load on latch, shift toward bit 0 on each pad_clk rise,
  // serial output is the current low bit, active-low.
  always @(posedge pad_latch) begin sr1 = btn1; sr2 = btn2; end
  always @(posedge pad_clk)   begin sr1 = {1'b0, sr1[7:1]}; sr2 = {1'b0, sr2[7:1]}; end
  assign pad1_data = ~sr1[0];
  assign pad2_data = ~sr2[0];

  always @(posedge latch1) begin sr1b = btn1; sr2b = btn2; end
  always @(posedge pclk1)  begin sr1b = {1'b0, sr1b[7:1]}; sr2b = {1'b0, sr2b[7:1]}; end
  assign pad1_b = ~sr1b[0];
  assign pad2_b = ~sr2b[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the DIV=2 instance: scoreboard pops and waveform timing.
  int  busy_run = 0, lat_run = 0, hi_run = 0, lo_run = 0, pulses = 0;
  bit  prev_busy = 0, prev_latch = 0, prev_pclk = 0, prev_valid = 0, overlap = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_run = 0; lat_run = 0; hi_run = 0; lo_run = 0; pulses = 0;
      prev_busy = 0; prev_latch = 0; prev_pclk = 0; prev_valid = 0; overlap = 0;
    end else begin
      if (pad_latch && pad_clk) overlap = 1;
      if (pad_latch) lat_run++;
      else if (prev_latch) begin
        check("latch_len", lat_run, 2 * DIV);
        lat_run = 0;
      end
      if (pad_clk) begin
        if (!prev_pclk) begin
          pulses++;
          if (pulses > 1) check("clk_low_len", lo_run, DIV);
        end
        hi_run++;
      end else begin
        if (prev_pclk) begin
          check("clk_high_len", hi_run, DIV);
          hi_run = 0;
          lo_run = 0;
        end
        if (busy) lo_run++;
      end
      if (busy) busy_run++;
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("joycon_1", joycon_1, e[15:8]);
          check("joycon_2", joycon_2, e[7:0]);
        end
        check("clk_pulses", pulses, 7);
        check("latch_clk_overlap", overlap, 0);
      end
      if (!busy && prev_busy) begin
        check("busy_len", busy_run, 17 * DIV + 1);
        check("valid_last_busy", prev_valid, 1);
        busy_run = 0; pulses = 0; overlap = 0; lo_run = 0;
      end
      prev_busy = busy; prev_latch = pad_latch; prev_pclk = pad_clk; prev_valid = valid;
    end
  end

  // Monitor for the DIV=1 instance: data and scan length.
  int busy_run1 = 0;
  bit prev_busy1 = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_run1 = 0; prev_busy1 = 0;
    end else begin
      if (busy1) busy_run1++;
      if (valid1) begin
        if (exp1_q.size() == 0) begin
          check("unexpected_valid_div1", 1, 0);
        end else begin
          logic [15:0] e;
          e = exp1_q.pop_front();
          check("div1_joycon_1", j1_1, e[15:8]);
          check("div1_joycon_2", j1_2, e[7:0]);
        end
      end
      if (!busy1 && prev_busy1) begin
        check("div1_busy_len", busy_run1, 17 * DIV1 + 1);
        busy_run1 = 0;
      end
      prev_busy1 = busy1;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("idle_timeout", busy, 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 300);
    if (n >= 300) check("valid_timeout", valid, 1);
  endtask

  task automatic do_poll(input logic [7:0] a, input logic [7:0] b, input bit push);
    wait_idle();
    @(negedge clk);
    btn1 = a;
    btn2 = b;
    if (push) exp_q.push_back({a, b});
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r1, r2;
    int cnt, n;
    bit prev, bad;

    // Reset held 3 edges with poll asserted; the first scan is the 5A/00 data case.
    exp_q.push_back({8'h5A, 8'h00});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {pad_latch, pad_clk, busy, valid, joycon_1, joycon_2}, 0);
      check("reset_outputs_div1", {latch1, pclk1, busy1, valid1, j1_1, j1_2}, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("scan_start_latch", pad_latch, 1);
    check("scan_start_busy", busy, 1);
    poll_req = 1'b0;
    wait_idle();

    // Random button patterns.
    for (int i = 0; i < 6; i++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      do_poll(r1, r2, 1);
    end
    do_poll(8'hFF, 8'hFF, 1);
    do_poll(8'h00, 8'h00, 1);

    // Requests mid-scan and during DONE are dropped.
    do_poll(8'hA5, 8'h3C, 1);
    repeat (10) @(negedge clk);
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    wait_valid();
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    repeat (3) @(negedge clk);
    check("overlap_no_rescan", busy, 0);

    // Held request: next LATCH two cycles after valid.
    wait_idle();
    @(negedge clk);
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    btn1 = r1;
    btn2 = r2;
    exp_q.push_back({r1, r2});
    exp_q.push_back({r1, r2});
    poll_req = 1'b1;
    wait_valid();
    @(negedge clk);
    check("held_gap_idle", {pad_latch, busy}, 0);
    @(negedge clk);
    check("held_relatch", pad_latch, 1);
    poll_req = 1'b0;
    wait_idle();

    // Abort during CLK_HI of bit 4.
    do_poll(8'hFF, 8'h0F, 1);
    do_poll(8'h3C, 8'h55, 0);
    cnt = 0; n = 0; prev = 0;
    while (cnt < 4 && n < 300) begin
      @(negedge clk);
      if (pad_clk && !prev) cnt++;
      prev = pad_clk;
      n++;
    end
    check("abort_reached_bit4", cnt, 4);
    rst = 1'b1;
    @(negedge clk);
    check("abort_clear", {joycon_1, joycon_2, busy, valid, pad_latch, pad_clk}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_stays_idle", {busy, joycon_1}, 0);
    do_poll(8'h81, 8'h00, 1);
    wait_idle();

    // Stability: joycon holds its value while pads change mid-scan.
    do_poll(8'h11, 8'h22, 1);
    do_poll(8'hC3, 8'h22, 1);
    repeat (10) @(negedge clk);
    btn1 = 8'h0F;
    bad = 0; n = 0;
    while (valid !== 1'b1 && n < 300) begin
      if (joycon_1 !== 8'h11 || joycon_2 !== 8'h22) bad = 1;
      @(negedge clk);
      n++;
    end
    check("hold_during_scan", bad, 0);
    wait_idle();

    // DIV=1 instance.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      btn1 = r1;
      btn2 = r2;
      exp1_q.push_back({r1, r2});
      poll1 = 1'b1;
      @(negedge clk);
      poll1 = 1'b0;
      n = 0;
      while (busy1 === 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) check("div1_timeout", busy1, 0);
    end

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("sb_drained_div1", exp1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
